ps2_mouse_ctrl: RTL and testbench

Sequencer and consumer for the PS/2 mouse receive interface. It holds the interface in reset at start-up and on ack failure, and retries the stream-enable handshake a bounded number of times. It drains each decoded packet via the `data_ready`/`read` handshake and integrates the 9-bit signed deltas into a clamped absolute cursor position for the display side.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_mouse_ctrl_if.sv | 24 ++
 rtl/ps2_axis_accum.sv | 53 +++++
 rtl/ps2_mouse_ctrl.sv | 142 ++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 mouse controller: FSM states, delta type,
// and the delta sign-extension helper.
package ps2_pkg;

    localparam int unsigned DefScreenW  = 640;
    localparam int unsigned DefScreenH  = 480;
    localparam int unsigned DefCoordBits = 10;

    typedef enum logic [2:0] {
        StInit,
        StWait,
        StCapture,
        StAccum,
        StRecover,
        StFault
    } state_e;

    typedef logic signed [8:0] delta_t;

    function automatic logic signed [15:0] sext_delta(delta_t d);
        return {{7{d[8]}}, d};
    endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Handshake bundle between the controller (master) and the PS/2 receive interface (slave).
interface ps2_mouse_ctrl_if;
    import ps2_pkg::*;

    logic   if_reset;
    logic   if_data_ready;
    logic   if_read;
    logic   if_error_no_ack;
    logic   if_left;
    logic   if_right;
    logic   if_middle;
    delta_t if_x_inc;
    delta_t if_y_inc;

    modport master (
        output if_reset, if_read,
        input  if_data_ready, if_error_no_ack, if_left, if_right, if_middle, if_x_inc, if_y_inc
    );

    modport slave (
        input  if_reset, if_read,
        output if_data_ready, if_error_no_ack, if_left, if_right, if_middle, if_x_inc, if_y_inc
    );
endinterface

// File: rtl/ps2_axis_accum.sv
// One cursor axis: adds (or subtracts) a signed 9-bit delta into a registered
// coordinate, saturating at 0 and EXT-1.
module ps2_axis_accum
    import ps2_pkg::*;
#(
    parameter int unsigned EXT        = DefScreenW,
    parameter int unsigned COORD_BITS = DefCoordBits,
    parameter int unsigned RESET_VAL  = DefScreenW / 2,
    parameter bit          INVERT     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  delta_t                delta_i,
    output logic [COORD_BITS-1:0] coord_o
);
    // Two guard bits hold both the negative and the >EXT-1 overflow cases.
    localparam int unsigned W = COORD_BITS + 2;
    localparam logic [COORD_BITS-1:0] MaxCoord = COORD_BITS'(EXT - 1);

    logic signed [15:0]    d_wide;
    logic signed [W-1:0]   d_ext;
    logic signed [W-1:0]   cur;
    logic signed [W-1:0]   sum;
    logic [COORD_BITS-1:0] coord_d, coord_q;

    always_comb begin
        d_wide  = sext_delta(delta_i);
        d_ext   = d_wide[W-1:0];
        cur     = signed'({2'b00, coord_q});
        sum     = INVERT ? (cur - d_ext) : (cur + d_ext);
        coord_d = coord_q;
        if (load_i) begin
            if (sum[W-1]) begin
                coord_d = '0;
            end else if (sum > signed'({2'b00, MaxCoord})) begin
                coord_d = MaxCoord;
            end else begin
                coord_d = sum[COORD_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coord_q <= COORD_BITS'(RESET_VAL);
        end else begin
            coord_q <= coord_d;
        end
    end

    assign coord_o = coord_q;
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: init/retry FSM around the receive interface, packet drain
// via data_ready/read, and clamped absolute cursor integration.
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DefScreenW,
    parameter int unsigned SCREEN_H     = DefScreenH,
    parameter int unsigned COORD_BITS   = DefCoordBits,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_mouse_ctrl_if.master      mouse,
    output logic [COORD_BITS-1:0] cursor_x,
    output logic [COORD_BITS-1:0] cursor_y,
    output logic                  left_button,
    output logic                  right_button,
    output logic                  middle_button,
    output logic                  update,
    output logic [3:0]            retry_count,
    output logic                  fault
);
    localparam int unsigned CntW = $clog2(RESET_CYCLES);
    localparam logic [CntW-1:0] CntLast  = CntW'(RESET_CYCLES - 1);
    localparam logic [3:0]      MaxRetry = 4'(MAX_RETRIES);

    state_e          state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [3:0]      retry_d, retry_q;
    logic            if_reset_q, if_read_q, update_q, fault_q;
    logic [2:0]      cap_btn_q, btn_q;
    delta_t          dx_q, dy_q;
    logic            load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            StInit: begin
                if (cnt_q == CntLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                // Ack failure wins over a coincident data_ready.
                if (mouse.if_error_no_ack) begin
                    state_d = StRecover;
                end else if (mouse.if_data_ready) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StAccum;
            StAccum: begin
                state_d = StWait;
                retry_d = '0;
            end
            StRecover: begin
                retry_d = retry_q + 4'd1;
                cnt_d   = '0;
                state_d = (retry_q + 4'd1 == MaxRetry) ? StFault : StInit;
            end
            StFault: state_d = StFault;
            default: state_d = StInit;
        endcase
    end

    assign load = (state_q == StAccum);

    // Strobe outputs are decoded from the next state so they align with the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            retry_q    <= '0;
            if_reset_q <= 1'b1;
            if_read_q  <= 1'b0;
            update_q   <= 1'b0;
            fault_q    <= 1'b0;
            cap_btn_q  <= '0;
            btn_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            if_reset_q <= (state_d == StInit) || (state_d == StFault);
            if_read_q  <= (state_d == StCapture);
            update_q   <= load;
            fault_q    <= (state_d == StFault);
            if (state_q == StCapture) begin
                cap_btn_q <= {mouse.if_middle, mouse.if_right, mouse.if_left};
                dx_q      <= mouse.if_x_inc;
                dy_q      <= mouse.if_y_inc;
            end
            if (load) begin
                btn_q <= cap_btn_q;
            end
        end
    end

    ps2_axis_accum #(
        .EXT        (SCREEN_W),
        .COORD_BITS (COORD_BITS),
        .RESET_VAL  (SCREEN_W / 2),
        .INVERT     (1'b0)
    ) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .delta_i (dx_q),
        .coord_o (cursor_x)
    );

    // PS/2 +Y is up, screen +Y is down.
    ps2_axis_accum #(
        .EXT        (SCREEN_H),
        .COORD_BITS (COORD_BITS),
        .RESET_VAL  (SCREEN_H / 2),
        .INVERT     (1'b1)
    ) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .delta_i (dy_q),
        .coord_o (cursor_y)
    );

    assign mouse.if_reset = if_reset_q;
    assign mouse.if_read  = if_read_q;
    assign update         = update_q;
    assign fault          = fault_q;
    assign retry_count    = retry_q;
    assign left_button    = btn_q[0];
    assign right_button   = btn_q[1];
    assign middle_button  = btn_q[2];
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: scoreboard of expected cursor/button
// updates plus per-scenario timing checks.
module tb_ps2_mouse_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_mouse_ctrl_if mif ();

    logic [9:0] cursor_x, cursor_y;
    logic       left_button, right_button, middle_button, update, fault;
    logic [3:0] retry_count;

    ps2_mouse_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .mouse         (mif),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .left_button   (left_button),
        .right_button  (right_button),
        .middle_button (middle_button),
        .update        (update),
        .retry_count   (retry_count),
        .fault         (fault)
    );

    typedef struct {
        int         x;
        int         y;
        logic [2:0] btn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   mx = 320;
    int   my = 240;
    logic prev_read = 1'b0;

    function automatic int clampi(int v, int ext);
        if (v < 0) return 0;
        if (v > ext - 1) return ext - 1;
        return v;
    endfunction

    // Scoreboard consumer: every update strobe must match the oldest expected packet.
    always @(negedge clk) begin
        if (update === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_update: got update=1 with no packet outstanding");
            end else begin
                mon_e = sb.pop_front();
                if (cursor_x !== mon_e.x[9:0] || cursor_y !== mon_e.y[9:0] ||
                    {middle_button, right_button, left_button} !== mon_e.btn) begin
                    miscompares++;
                    $display("FAIL sb_packet: got (%0d,%0d,btn=%b) want (%0d,%0d,btn=%b)",
                             cursor_x, cursor_y, {middle_button, right_button, left_button},
                             mon_e.x, mon_e.y, mon_e.btn);
                end
            end
        end
        if (if_read_high() && prev_read) begin
            vectors++;
            miscompares++;
            $display("FAIL read_twice: if_read high on two consecutive cycles");
        end
        prev_read = mif.if_read;
    end

    function automatic bit if_read_high();
        return mif.if_read === 1'b1;
    endfunction

    task automatic count_if_reset(output int n);
        n = 0;
        while (mif.if_reset === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_packet(input logic [8:0] xi, input logic [8:0] yi, input logic [2:0] b);
        logic signed [8:0] sx, sy;
        exp_t e;
        @(negedge clk);
        mif.if_data_ready = 1'b1;
        mif.if_x_inc = xi;
        mif.if_y_inc = yi;
        {mif.if_middle, mif.if_right, mif.if_left} = b;
        sx = xi;
        sy = yi;
        mx = clampi(mx + int'(sx), 640);
        my = clampi(my - int'(sy), 480);
        e.x = mx;
        e.y = my;
        e.btn = b;
        sb.push_back(e);
        @(negedge clk);
        vectors++;
        if (mif.if_read !== 1'b1) begin
            miscompares++;
            $display("FAIL read_pulse: if_read=%b want 1 at N+1", mif.if_read);
        end
        @(negedge clk);
        mif.if_data_ready = 1'b0;
        vectors++;
        if (mif.if_read !== 1'b0) begin
            miscompares++;
            $display("FAIL read_drop: if_read=%b want 0 at N+2", mif.if_read);
        end
    endtask

    // Drives one ack failure from WAIT; returns at the first cycle of the following state.
    task automatic inject_error(input logic with_ready, input logic [3:0] exp_retry,
                                input logic exp_fault);
        @(negedge clk);
        mif.if_error_no_ack = 1'b1;
        mif.if_data_ready = with_ready;
        @(negedge clk);
        vectors++;
        if (mif.if_reset !== 1'b0 || mif.if_read !== 1'b0) begin
            miscompares++;
            $display("FAIL recover_cycle: if_reset=%b if_read=%b want 0 0",
                     mif.if_reset, mif.if_read);
        end
        mif.if_error_no_ack = 1'b0;
        mif.if_data_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (retry_count !== exp_retry || mif.if_reset !== 1'b1 || fault !== exp_fault) begin
            miscompares++;
            $display("FAIL retry_step: retry=%0d if_reset=%b fault=%b want %0d 1 %b",
                     retry_count, mif.if_reset, fault, exp_retry, exp_fault);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (mif.if_reset !== 1'b1 || mif.if_read !== 1'b0 || update !== 1'b0 ||
            fault !== 1'b0 || retry_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: if_reset=%b read=%b upd=%b fault=%b retry=%0d",
                     mif.if_reset, mif.if_read, update, fault, retry_count);
        end
        vectors++;
        if (cursor_x !== 10'd320 || cursor_y !== 10'd240 ||
            {middle_button, right_button, left_button} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_cursor: got (%0d,%0d) want (320,240)", cursor_x, cursor_y);
        end
        reset = 1'b1;
        count_if_reset(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL init_len: if_reset high %0d cycles want 16", n);
        end
        mx = 320;
        my = 240;
    endtask

    task automatic test_packet();
        send_packet(9'h00A, 9'h1FB, 3'b001);
        @(negedge clk);
        vectors++;
        if (update !== 1'b1 || cursor_x !== 10'd330 || cursor_y !== 10'd245 ||
            left_button !== 1'b1) begin
            miscompares++;
            $display("FAIL first_packet: upd=%b (%0d,%0d) left=%b want 1 (330,245) 1",
                     update, cursor_x, cursor_y, left_button);
        end
        @(negedge clk);
        vectors++;
        if (update !== 1'b0) begin
            miscompares++;
            $display("FAIL update_width: update=%b want 0 at N+4", update);
        end
    endtask

    task automatic test_clamp();
        send_packet(9'h100, 9'h000, 3'b010);
        send_packet(9'h100, 9'h000, 3'b010);
        send_packet(9'h000, 9'h0FF, 3'b100);
        send_packet(9'h000, 9'h0FF, 3'b100);
        repeat (2) @(negedge clk);
        vectors++;
        if (cursor_x !== 10'd0 || cursor_y !== 10'd0) begin
            miscompares++;
            $display("FAIL clamp_low: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
        end
        for (int i = 0; i < 3; i++) send_packet(9'h0FF, 9'h000, 3'b000);
        send_packet(9'h000, 9'h000, 3'b111);
        repeat (2) @(negedge clk);
        vectors++;
        if (cursor_x !== 10'd639) begin
            miscompares++;
            $display("FAIL clamp_high: cursor_x=%0d want 639", cursor_x);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send_packet(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                        3'($urandom_range(0, 7)));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_err_priority();
        int n;
        inject_error(1'b1, 4'd1, 1'b0);
        count_if_reset(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL recover_len: if_reset high %0d cycles want 16", n);
        end
        send_packet(9'h003, 9'h1FE, 3'b000);
        @(negedge clk);
        vectors++;
        if (retry_count !== 4'd0 || update !== 1'b1) begin
            miscompares++;
            $display("FAIL retry_clear: retry=%0d upd=%b want 0 1", retry_count, update);
        end
        @(negedge clk);
    endtask

    task automatic test_retry_fault();
        int n;
        int reads;
        inject_error(1'b0, 4'd1, 1'b0);
        count_if_reset(n);
        inject_error(1'b0, 4'd2, 1'b0);
        count_if_reset(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL recover2_len: if_reset high %0d cycles want 16", n);
        end
        inject_error(1'b0, 4'd3, 1'b1);
        mif.if_data_ready = 1'b1;
        reads = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.if_read === 1'b1) reads++;
            if (mif.if_reset !== 1'b1 || fault !== 1'b1) n++;
        end
        mif.if_data_ready = 1'b0;
        vectors++;
        if (reads != 0 || n != 0) begin
            miscompares++;
            $display("FAIL fault_hold: reads=%0d lapses=%0d want 0 0", reads, n);
        end
    endtask

    task automatic test_reset_mid_accum();
        int n;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        count_if_reset(n);
        mx = 320;
        my = 240;
        send_packet(9'h014, 9'h00A, 3'b011);
        @(negedge clk);
        // Second packet is aborted by reset while the DUT is in ACCUM.
        send_packet(9'h050, 9'h1C0, 3'b100);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (cursor_x !== 10'd320 || cursor_y !== 10'd240 ||
            {middle_button, right_button, left_button} !== 3'b000 ||
            mif.if_reset !== 1'b1 || mif.if_read !== 1'b0 || update !== 1'b0 ||
            retry_count !== 4'd0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: (%0d,%0d) btn=%b rst=%b rd=%b upd=%b retry=%0d fault=%b",
                     cursor_x, cursor_y, {middle_button, right_button, left_button},
                     mif.if_reset, mif.if_read, update, retry_count, fault);
        end
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mx = 320;
        my = 240;
        count_if_reset(n);
        send_packet(9'h1F6, 9'h001, 3'b101);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        mif.if_data_ready = 1'b0;
        mif.if_error_no_ack = 1'b0;
        mif.if_left = 1'b0;
        mif.if_right = 1'b0;
        mif.if_middle = 1'b0;
        mif.if_x_inc = '0;
        mif.if_y_inc = '0;
        test_reset();
        test_packet();
        test_clamp();
        test_back_to_back();
        test_err_priority();
        test_retry_fault();
        test_reset_mid_accum();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d packets never produced update, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
